// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, widths and baud divider helper
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam int OVS_DEF = 16;
    localparam int DATA_W  = 8;

    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversampling tick divider, held at zero while disabled
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // count 0..DIV-1 while enabled; clearing when disabled aligns sampling to the start edge
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) cnt <= '0;
        else        cnt <= (en && cnt != LAST) ? cnt + 1'b1 : '0;

    assign tick = en && cnt == LAST;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with oversampling, 3-sample majority vote and glitch rejection
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = OVS_DEF,
    parameter int DIV    = calc_div(CLK_HZ, BAUD, OVS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] S_A   = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_B   = SW'(OVS / 2);
    localparam logic [SW-1:0] S_C   = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVS - 1);

    logic [1:0]        sync;
    logic              rxs;
    state_t            state, state_n;
    logic              tick;
    logic [SW-1:0]     s;
    logic [2:0]        bi;
    logic [DATA_W-1:0] shift;
    logic [1:0]        smp;
    logic              vote_at, wrap, vote;

    assign rxs     = sync[1];
    assign vote_at = tick && s == S_C;
    assign wrap    = tick && s == S_END;
    assign vote    = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
    assign busy    = state != IDLE;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (state != IDLE),
        .tick  (tick)
    );

    // two-flop synchroniser, preset to the idle line level
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) sync <= 2'b11;
        else        sync <= {sync[0], rxd};

    // state register
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) state <= IDLE;
        else        state <= state_n;

    // next state: stop is judged at mid-bit so a following start edge is never missed
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!rxs) state_n = START;
            START:   state_n = (vote_at && vote) ? IDLE : (wrap ? DATA : START);
            DATA:    if (wrap && bi == 3'd7) state_n = STOP;
            STOP:    if (vote_at) state_n = vote ? IDLE : BRK;
            BRK:     if (rxs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // sample counter, vote samples, bit index, shift register and output strobes
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            s         <= '0;
            bi        <= '0;
            smp       <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= state == STOP && vote_at && vote;
            frame_err <= state == STOP && vote_at && !vote;
            s         <= (state == IDLE) ? '0 : (tick ? s + 1'b1 : s);
            if (tick && s == S_A) smp[0] <= rxs;
            if (tick && s == S_B) smp[1] <= rxs;
            if (state == START) bi <= '0;
            else if (state == DATA && wrap) bi <= bi + 1'b1;
            if (state == DATA && vote_at) shift <= {vote, shift[DATA_W-1:1]};
            if (state == STOP && vote_at && vote) rx_data <= shift;
        end

endmodule
